// File: rtl/mc_ctrl_pkg.sv
// Shared state encodings, MIPS opcode/funct constants and control code values
// for the multi-cycle controller.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    localparam logic [2:0] NPC_PLUS4  = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_REG    = 3'd2;
    localparam logic [2:0] NPC_JUMP   = 3'd3;

    localparam logic [3:0] REGW_SRC_ALU = 4'd0;
    localparam logic [3:0] REGW_SRC_MEM = 4'd1;
    localparam logic [3:0] REGW_SRC_LUI = 4'd2;
    localparam logic [3:0] REGW_SRC_PC  = 4'd3;

    localparam logic [3:0] REGW_DST_RT  = 4'd0;
    localparam logic [3:0] REGW_DST_RD  = 4'd1;
    localparam logic [3:0] REGW_DST_R31 = 4'd2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_LUI = 3'd4;

    localparam logic [2:0] ALUSRC_REG   = 3'd0;
    localparam logic [2:0] ALUSRC_IMM   = 3'd1;
    localparam logic [2:0] ALUSRC_SHAMT = 3'd2;

    localparam logic [2:0] EXT_SIGN  = 3'd0;
    localparam logic [2:0] EXT_ZERO  = 3'd1;
    localparam logic [2:0] EXT_UPPER = 3'd2;

endpackage

// File: rtl/mc_decode.sv
// Purely combinational instruction decoder: instruction word to class flags
// and the static ALU / extend / write-back codes for that instruction.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_j,
    output logic        is_jal,
    output logic        is_jr,
    output logic        is_beq,
    output logic        is_lw,
    output logic        is_sw,
    output logic        is_alu,
    output logic [3:0]  wb_dst,
    output logic [3:0]  wb_src,
    output logic [2:0]  alu_op,
    output logic [2:0]  alu_src,
    output logic [2:0]  ext_op
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    // Register and immediate fields are routed by the datapath, not decoded here.
    assign unused_fields = ^instr[25:6];

    always_comb begin
        is_j    = 1'b0;
        is_jal  = 1'b0;
        is_jr   = 1'b0;
        is_beq  = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_alu  = 1'b0;
        wb_dst  = REGW_DST_RT;
        wb_src  = REGW_SRC_ALU;
        alu_op  = ALU_ADD;
        alu_src = ALUSRC_REG;
        ext_op  = EXT_SIGN;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        is_alu = 1'b1;
                        wb_dst = REGW_DST_RD;
                    end
                    FN_SUB: begin
                        is_alu = 1'b1;
                        wb_dst = REGW_DST_RD;
                        alu_op = ALU_SUB;
                    end
                    FN_SLL: begin
                        is_alu  = 1'b1;
                        wb_dst  = REGW_DST_RD;
                        alu_op  = ALU_SLL;
                        alu_src = ALUSRC_SHAMT;
                    end
                    FN_JR:   is_jr = 1'b1;
                    default: ;
                endcase
            end
            OP_J:   is_j = 1'b1;
            OP_JAL: is_jal = 1'b1;
            OP_BEQ: begin
                is_beq = 1'b1;
                alu_op = ALU_SUB;
            end
            OP_ORI: begin
                is_alu  = 1'b1;
                alu_op  = ALU_OR;
                alu_src = ALUSRC_IMM;
                ext_op  = EXT_ZERO;
            end
            OP_LUI: begin
                is_alu  = 1'b1;
                alu_op  = ALU_LUI;
                alu_src = ALUSRC_IMM;
                ext_op  = EXT_UPPER;
                wb_src  = REGW_SRC_LUI;
            end
            OP_LW: begin
                is_lw   = 1'b1;
                alu_src = ALUSRC_IMM;
                wb_src  = REGW_SRC_MEM;
            end
            OP_SW: begin
                is_sw   = 1'b1;
                alu_src = ALUSRC_IMM;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB FSM with
// combinational enables qualified by mem_ack and zero.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        regw_enable,
    output logic [2:0]  nPC_sel,
    output logic [2:0]  alu_op,
    output logic [2:0]  alu_src,
    output logic [2:0]  ext_op,
    output logic [3:0]  regw_src,
    output logic [3:0]  regw_dst,
    output logic [2:0]  state,
    output logic        instr_done
);

    state_t     state_q, state_d;
    logic       dec_j, dec_jal, dec_jr, dec_beq, dec_lw, dec_sw, dec_alu;
    logic [3:0] dec_wb_dst, dec_wb_src;
    logic [2:0] dec_alu_op, dec_alu_src, dec_ext_op;

    mc_decode u_decode (
        .instr   (instr),
        .is_j    (dec_j),
        .is_jal  (dec_jal),
        .is_jr   (dec_jr),
        .is_beq  (dec_beq),
        .is_lw   (dec_lw),
        .is_sw   (dec_sw),
        .is_alu  (dec_alu),
        .wb_dst  (dec_wb_dst),
        .wb_src  (dec_wb_src),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .ext_op  (dec_ext_op)
    );

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        mdr_we      = 1'b0;
        regw_enable = 1'b0;
        instr_done  = 1'b0;
        nPC_sel     = NPC_PLUS4;
        regw_src    = REGW_SRC_ALU;
        regw_dst    = REGW_DST_RT;
        alu_op      = dec_alu_op;
        alu_src     = dec_alu_src;
        ext_op      = dec_ext_op;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_j || dec_jal || dec_jr) begin
                    pc_we   = 1'b1;
                    nPC_sel = dec_jr ? NPC_REG : NPC_JUMP;
                end
                if (dec_jal) begin
                    regw_enable = 1'b1;
                    regw_dst    = REGW_DST_R31;
                    regw_src    = REGW_SRC_PC;
                end
                if (dec_beq || dec_lw || dec_sw || dec_alu) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d    = ST_FETCH;
                    instr_done = 1'b1;
                end
            end
            ST_EXEC: begin
                if (dec_beq) begin
                    pc_we      = zero;
                    nPC_sel    = NPC_BRANCH;
                    state_d    = ST_FETCH;
                    instr_done = 1'b1;
                end else if (dec_lw || dec_sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = dec_sw;
                if (mem_ack) begin
                    if (dec_lw) begin
                        mdr_we  = 1'b1;
                        state_d = ST_WB;
                    end else begin
                        state_d    = ST_FETCH;
                        instr_done = 1'b1;
                    end
                end
            end
            ST_WB: begin
                regw_enable = 1'b1;
                regw_dst    = dec_wb_dst;
                regw_src    = dec_wb_src;
                state_d     = ST_FETCH;
                instr_done  = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
        // Reset gates the outputs directly so an in-flight request drops before any edge.
        if (reset) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            pc_we       = 1'b0;
            ir_we       = 1'b0;
            mdr_we      = 1'b0;
            regw_enable = 1'b0;
            instr_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven bench for mc_ctrl: per-cycle input/expected-output records plus
// hand-written reset sequences.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, pc_we, ir_we, mdr_we, regw_enable, instr_done;
    logic [2:0]  nPC_sel, alu_op, alu_src, ext_op, state;
    logic [3:0]  regw_src, regw_dst;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .zero        (zero),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .pc_we       (pc_we),
        .ir_we       (ir_we),
        .mdr_we      (mdr_we),
        .regw_enable (regw_enable),
        .nPC_sel     (nPC_sel),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .ext_op      (ext_op),
        .regw_src    (regw_src),
        .regw_dst    (regw_dst),
        .state       (state),
        .instr_done  (instr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        zero, ack;
        logic [2:0]  st;
        logic        req, we, pcwe, irwe, mdr, rw, done;
        logic [2:0]  npc;
        logic [3:0]  dst, src;
        logic [2:0]  alu;
    } vec_t;

    localparam logic [31:0] I_ADD = 32'h00221820;
    localparam logic [31:0] I_LW  = 32'h8C080004;
    localparam logic [31:0] I_BEQ = 32'h10000001;
    localparam logic [31:0] I_JAL = 32'h0C000003;
    localparam logic [31:0] I_UNK = 32'hFC000000;
    localparam logic [31:0] I_SW  = 32'hAC080004;
    localparam logic [31:0] I_J   = 32'h08000000;
    localparam logic [31:0] I_JR  = 32'h03E00008;
    localparam logic [31:0] I_ORI = 32'h34210005;
    localparam logic [31:0] I_LUI = 32'h3C011234;

    function automatic vec_t v(logic [31:0] i, logic z, logic a, logic [2:0] st,
                               logic req, logic we, logic pcwe, logic irwe, logic mdr,
                               logic rw, logic done, logic [2:0] npc, logic [3:0] dst,
                               logic [3:0] src, logic [2:0] alu);
        vec_t r;
        r.instr = i; r.zero = z; r.ack = a; r.st = st;
        r.req = req; r.we = we; r.pcwe = pcwe; r.irwe = irwe; r.mdr = mdr;
        r.rw = rw; r.done = done; r.npc = npc; r.dst = dst; r.src = src; r.alu = alu;
        return r;
    endfunction

    // Zero-wait FETCH and quiet DECODE records.
    function automatic vec_t vf(logic [31:0] i, logic z);
        return v(i, z, 1'b1, 3'd0, 1, 0, 1, 1, 0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd0);
    endfunction

    function automatic vec_t vd(logic [31:0] i, logic z, logic a);
        return v(i, z, a, 3'd1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd0);
    endfunction

    // nPC_sel compared only when pc_we is expected, write-back codes only with
    // regw_enable, ALU code only in EXEC/MEM/WB.
    task automatic check(input string nm, input vec_t e);
        logic bad;
        bad = (state !== e.st) || (mem_req !== e.req) || (mem_we !== e.we) ||
              (pc_we !== e.pcwe) || (ir_we !== e.irwe) || (mdr_we !== e.mdr) ||
              (regw_enable !== e.rw) || (instr_done !== e.done);
        if (e.pcwe && nPC_sel !== e.npc) bad = 1'b1;
        if (e.rw && (regw_dst !== e.dst || regw_src !== e.src)) bad = 1'b1;
        if ((e.st == 3'd2 || e.st == 3'd3 || e.st == 3'd4) && alu_op !== e.alu) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s: got st=%0d req=%b we=%b pcwe=%b irwe=%b mdr=%b rw=%b done=%b npc=%0d dst=%0d src=%0d alu=%0d; want st=%0d req=%b we=%b pcwe=%b irwe=%b mdr=%b rw=%b done=%b npc=%0d dst=%0d src=%0d alu=%0d",
                     nm, state, mem_req, mem_we, pc_we, ir_we, mdr_we, regw_enable, instr_done,
                     nPC_sel, regw_dst, regw_src, alu_op,
                     e.st, e.req, e.we, e.pcwe, e.irwe, e.mdr, e.rw, e.done,
                     e.npc, e.dst, e.src, e.alu);
        end
    endtask

    vec_t tbl[$];
    vec_t idle;

    initial begin
        idle = v(I_ADD, 0, 1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd0);

        // add: F D E W, write rd in cycle 4
        tbl.push_back(vf(I_ADD, 0));
        tbl.push_back(vd(I_ADD, 0, 1));
        tbl.push_back(v(I_ADD, 0, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, ALU_ADD));
        tbl.push_back(v(I_ADD, 0, 1, 3'd4, 0, 0, 0, 0, 0, 1, 1, 3'd0, 4'd1, 4'd0, ALU_ADD));
        // lw with three wait cycles in MEM: 8 cycles total
        tbl.push_back(vf(I_LW, 0));
        tbl.push_back(vd(I_LW, 0, 0));
        tbl.push_back(v(I_LW, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, ALU_ADD));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(I_LW, 0, 0, 3'd3, 1, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, ALU_ADD));
        tbl.push_back(v(I_LW, 0, 1, 3'd3, 1, 0, 0, 0, 1, 0, 0, 3'd0, 4'd0, 4'd0, ALU_ADD));
        tbl.push_back(v(I_LW, 0, 0, 3'd4, 0, 0, 0, 0, 0, 1, 1, 3'd0, 4'd0, 4'd1, ALU_ADD));
        // beq not taken, then taken
        tbl.push_back(vf(I_BEQ, 0));
        tbl.push_back(vd(I_BEQ, 0, 1));
        tbl.push_back(v(I_BEQ, 0, 1, 3'd2, 0, 0, 0, 0, 0, 0, 1, 3'd1, 4'd0, 4'd0, ALU_SUB));
        tbl.push_back(vf(I_BEQ, 1));
        tbl.push_back(vd(I_BEQ, 1, 1));
        tbl.push_back(v(I_BEQ, 1, 1, 3'd2, 0, 0, 1, 0, 0, 0, 1, 3'd1, 4'd0, 4'd0, ALU_SUB));
        // jal: link r31 <- PC in DECODE; following FETCH proves 2-cycle latency
        tbl.push_back(vf(I_JAL, 0));
        tbl.push_back(v(I_JAL, 0, 1, 3'd1, 0, 0, 1, 0, 0, 1, 1, 3'd3, 4'd2, 4'd3, 3'd0));
        // unknown opcode: no-op, no enables
        tbl.push_back(vf(I_UNK, 0));
        tbl.push_back(v(I_UNK, 0, 1, 3'd1, 0, 0, 0, 0, 0, 0, 1, 3'd0, 4'd0, 4'd0, 3'd0));
        // sw zero-wait: 4 cycles
        tbl.push_back(vf(I_SW, 0));
        tbl.push_back(vd(I_SW, 0, 1));
        tbl.push_back(v(I_SW, 0, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, ALU_ADD));
        tbl.push_back(v(I_SW, 0, 1, 3'd3, 1, 1, 0, 0, 0, 0, 1, 3'd0, 4'd0, 4'd0, ALU_ADD));
        // j and jr
        tbl.push_back(vf(I_J, 0));
        tbl.push_back(v(I_J, 0, 1, 3'd1, 0, 0, 1, 0, 0, 0, 1, 3'd3, 4'd0, 4'd0, 3'd0));
        tbl.push_back(vf(I_JR, 0));
        tbl.push_back(v(I_JR, 0, 1, 3'd1, 0, 0, 1, 0, 0, 0, 1, 3'd2, 4'd0, 4'd0, 3'd0));
        // ori and lui write rt
        tbl.push_back(vf(I_ORI, 0));
        tbl.push_back(vd(I_ORI, 0, 1));
        tbl.push_back(v(I_ORI, 0, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, ALU_OR));
        tbl.push_back(v(I_ORI, 0, 1, 3'd4, 0, 0, 0, 0, 0, 1, 1, 3'd0, 4'd0, 4'd0, ALU_OR));
        tbl.push_back(vf(I_LUI, 0));
        tbl.push_back(vd(I_LUI, 0, 1));
        tbl.push_back(v(I_LUI, 0, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, ALU_LUI));
        tbl.push_back(v(I_LUI, 0, 1, 3'd4, 0, 0, 0, 0, 0, 1, 1, 3'd0, 4'd0, 4'd2, ALU_LUI));
        // FETCH waits one cycle for ack
        tbl.push_back(v(I_ADD, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd0));
        tbl.push_back(vf(I_ADD, 0));
        tbl.push_back(vd(I_ADD, 0, 0));

        // Asynchronous reset before any clock edge, with ack high
        mem_ack = 1'b1;
        instr   = I_ADD;
        #1 reset = 1'b1;
        #1 check("reset_async", idle);
        @(negedge clk);
        check("reset_held", idle);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            instr   = tbl[i].instr;
            zero    = tbl[i].zero;
            mem_ack = tbl[i].ack;
            #1 check($sformatf("vec%0d", i), tbl[i]);
            @(negedge clk);
        end

        // Finish the in-flight add (EXEC, WB) before the reset scenario
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // sw: reset mid-cycle during MEM drops mem_req before the next edge
        instr = I_SW; zero = 1'b0; mem_ack = 1'b1;
        #1 check("sw_fetch", vf(I_SW, 0));
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("sw_mem_wait",
                 v(I_SW, 0, 0, 3'd3, 1, 1, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, ALU_ADD));
        #1 reset = 1'b1;
        #1 check("sw_mem_reset",
                 v(I_SW, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd0));
        @(negedge clk);
        reset = 1'b0;
        #1 check("post_reset_fetch",
                 v(I_SW, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd0));
        @(negedge clk);
        #1 check("post_reset_no_wb",
                 v(I_SW, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
